// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: FTW accumulation through 4-bit ripple slices, static phase offset,
// registered truncated phase with wrap pulse, and immediate or at-wrap tuning-word update.
module dds_phase_accum #(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic                 upd_at_wrap,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic [ACC_WIDTH-1:0] phase_off,
    output logic [OUT_WIDTH-1:0] phase_out,
    output logic                 phase_valid,
    output logic                 wrap
);

    localparam int unsigned NUM_SLICES = ACC_WIDTH / 4;
    localparam int unsigned OUT_SHIFT  = ACC_WIDTH - OUT_WIDTH;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic [ACC_WIDTH-1:0]   ftw_active;
    logic [ACC_WIDTH-1:0]   ftw_active_nxt;
    logic [ACC_WIDTH-1:0]   ftw_shadow;
    logic [ACC_WIDTH-1:0]   ftw_shadow_nxt;
    logic                   wrap_nxt;
    logic                   en_d;
    logic                   xfer;
    logic [ACC_WIDTH:0]     add_res;
    logic [OUT_WIDTH-1:0]   phase_top;

    // Chain of 4-bit slices; each slice's carry-out is the next slice's carry-in.
    function automatic logic [ACC_WIDTH:0] ripple_add(
        input logic [ACC_WIDTH-1:0] a,
        input logic [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH-1:0] sum;
        logic                 carry;
        logic [4:0]           slice;
        sum   = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < NUM_SLICES; i++) begin
            slice            = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(carry);
            sum[4*i +: 4]    = slice[3:0];
            carry            = slice[4];
        end
        return {carry, sum};
    endfunction

    assign add_res   = ripple_add(acc, ftw_active);
    // Offset carry is dropped by the ACC_WIDTH-wide sum before truncation.
    assign phase_top = OUT_WIDTH'(ACC_WIDTH'(acc + phase_off) >> OUT_SHIFT);
    assign xfer      = ftw_valid & ftw_ready;

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        ftw_active_nxt = ftw_active;
        ftw_shadow_nxt = ftw_shadow;
        wrap_nxt       = 1'b0;

        if (sync_clr) begin
            acc_nxt = '0;
        end else if (en) begin
            acc_nxt  = add_res[ACC_WIDTH-1:0];
            wrap_nxt = add_res[ACC_WIDTH];
        end

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (upd_at_wrap) begin
                        ftw_shadow_nxt = ftw_in;
                        state_nxt      = PENDING;
                    end else begin
                        ftw_active_nxt = ftw_in;
                    end
                end
            end
            PENDING: begin
                // The wrapping accumulation itself still used the old word.
                if (en && !sync_clr && add_res[ACC_WIDTH]) begin
                    ftw_active_nxt = ftw_shadow;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            ftw_active  <= '0;
            ftw_shadow  <= '0;
            ftw_ready   <= 1'b0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
            en_d        <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            ftw_active  <= ftw_active_nxt;
            ftw_shadow  <= ftw_shadow_nxt;
            ftw_ready   <= (state_nxt == IDLE);
            phase_out   <= phase_top;
            en_d        <= en;
            phase_valid <= en_d;
            wrap        <= wrap_nxt;
        end
    end

endmodule
